// File: rtl/rc4_pkg.sv
// Shared types and sizing for the RC4 keystream engine and its key selector.
package rc4_pkg;
  localparam int SBOX_SIZE   = 256;
  localparam int INIT_CYCLES = 128;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA_RD,
    KSA_SW,
    PRGA_RD,
    PRGA_SW,
    PRGA_OUT,
    PRGA_WAIT
  } state_t;
endpackage

// File: rtl/rc4_key_sel.sv
// Holds the latched key and length and walks the key index k during KSA.
// k wraps at len_q-1 by compare, so no divider is needed for key_len that is not a power of two.
module rc4_key_sel #(
  parameter  int MAX_KEY_BYTES = 16,
  localparam int KW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1,
  localparam int LW = $clog2(MAX_KEY_BYTES) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [LW-1:0]              key_len,
  input  logic                       clear,
  input  logic                       advance,
  output logic [7:0]                 key_byte
);
  logic [8*MAX_KEY_BYTES-1:0] key_q;
  logic [LW-1:0]              len_q;
  logic [KW-1:0]              k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      len_q <= '0;
      k     <= '0;
    end else if (load) begin
      key_q <= key;
      len_q <= key_len;
      k     <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (advance) begin
      if (LW'(k) == len_q - LW'(1)) k <= '0;
      else                          k <= k + KW'(1);
    end
  end

  assign key_byte = key_q[{k, 3'b000} +: 8];
endmodule

// File: rtl/rc4_engine.sv
// RC4 sequencer over a 3-port S-box RAM: identity init, KSA, then PRGA bytes on valid/ready.
// First byte 643 clocks after a valid start; at least 4 clocks per byte, held while ks_ready is low.
module rc4_engine
  import rc4_pkg::*;
#(
  parameter  int MAX_KEY_BYTES = 16,
  localparam int LW = $clog2(MAX_KEY_BYTES) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [LW-1:0]              key_len,
  output logic                       busy,
  output logic                       err,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic [7:0]                 ks_data,
  output logic                       ram_wen,
  output logic [7:0]                 ram_raddr_1,
  input  logic [7:0]                 ram_rdata_1,
  output logic [7:0]                 ram_waddr_2,
  output logic [7:0]                 ram_wdata_2,
  output logic [7:0]                 ram_addr_3,
  input  logic [7:0]                 ram_rdata_3,
  output logic [7:0]                 ram_wdata_3
);
  state_t     state;
  logic [7:0] i, j, t;
  logic [6:0] cnt;
  logic [7:0] key_byte;
  logic       len_ok;
  logic       init_last;

  assign len_ok    = (key_len != '0) && (key_len <= LW'(MAX_KEY_BYTES));
  assign init_last = (state == INIT) && (cnt == 7'(INIT_CYCLES - 1));

  rc4_key_sel #(.MAX_KEY_BYTES(MAX_KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start && len_ok),
    .key      (key),
    .key_len  (key_len),
    .clear    (init_last),
    .advance  (state == KSA_RD),
    .key_byte (key_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      t        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
    end else begin
      err <= 1'b0;
      if (start) begin
        // Any start aborts whatever is in flight, including a pending byte.
        ks_valid <= 1'b0;
        i        <= '0;
        j        <= '0;
        cnt      <= '0;
        if (len_ok) begin
          state <= INIT;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b1;
        end
      end else begin
        case (state)
          INIT: begin
            cnt <= cnt + 7'd1;
            if (init_last) begin
              state <= KSA_RD;
              i     <= '0;
              j     <= '0;
            end
          end
          KSA_RD: begin
            j     <= j + ram_rdata_1 + key_byte;
            state <= KSA_SW;
          end
          KSA_SW: begin
            if (i == 8'(SBOX_SIZE - 1)) begin
              state <= PRGA_RD;
              i     <= '0;
              j     <= '0;
              busy  <= 1'b0;
            end else begin
              i     <= i + 8'd1;
              state <= KSA_RD;
            end
          end
          PRGA_RD: begin
            i     <= i + 8'd1;
            j     <= j + ram_rdata_1;
            state <= PRGA_SW;
          end
          PRGA_SW: begin
            // Sum of the two cells is the same before and after the swap.
            t     <= ram_rdata_1 + ram_rdata_3;
            state <= PRGA_OUT;
          end
          PRGA_OUT: begin
            ks_data  <= ram_rdata_1;
            ks_valid <= 1'b1;
            state    <= PRGA_WAIT;
          end
          PRGA_WAIT: begin
            if (ks_ready) begin
              ks_valid <= 1'b0;
              state    <= PRGA_RD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // RAM addressing is decoded from registered state so reads land in the same cycle.
  always_comb begin
    ram_wen     = 1'b0;
    ram_raddr_1 = '0;
    ram_waddr_2 = '0;
    ram_wdata_2 = '0;
    ram_addr_3  = '0;
    ram_wdata_3 = '0;
    case (state)
      INIT: begin
        ram_wen     = 1'b1;
        ram_waddr_2 = {cnt, 1'b0};
        ram_wdata_2 = {cnt, 1'b0};
        ram_addr_3  = {cnt, 1'b1};
        ram_wdata_3 = {cnt, 1'b1};
      end
      KSA_RD:   ram_raddr_1 = i;
      PRGA_RD:  ram_raddr_1 = i + 8'd1;
      PRGA_OUT: ram_raddr_1 = t;
      KSA_SW, PRGA_SW: begin
        ram_raddr_1 = i;
        ram_addr_3  = j;
        ram_wen     = 1'b1;
        ram_waddr_2 = i;
        ram_wdata_2 = ram_rdata_3;
        ram_wdata_3 = ram_rdata_1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine with a behavioural 3-port S-box RAM and published RC4 vectors.
module tb_rc4_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [4:0]   key_len;
  logic         busy, err, ks_valid, ks_ready;
  logic [7:0]   ks_data;
  logic         ram_wen;
  logic [7:0]   ram_raddr_1, ram_rdata_1, ram_waddr_2, ram_wdata_2;
  logic [7:0]   ram_addr_3, ram_rdata_3, ram_wdata_3;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_bytes [0:15];
  logic [7:0] sbox [0:255];

  logic [7:0] exp_key    [0:9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] exp_wiki   [0:5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
  logic [7:0] exp_secret [0:7] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

  localparam logic [127:0] KEY_KEY    = 128'h79654B;
  localparam logic [127:0] KEY_WIKI   = 128'h696B6957;
  localparam logic [127:0] KEY_SECRET = 128'h746572636553;

  always #5 clk = ~clk;

  rc4_engine #(.MAX_KEY_BYTES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key         (key),
    .key_len     (key_len),
    .busy        (busy),
    .err         (err),
    .ks_valid    (ks_valid),
    .ks_ready    (ks_ready),
    .ks_data     (ks_data),
    .ram_wen     (ram_wen),
    .ram_raddr_1 (ram_raddr_1),
    .ram_rdata_1 (ram_rdata_1),
    .ram_waddr_2 (ram_waddr_2),
    .ram_wdata_2 (ram_wdata_2),
    .ram_addr_3  (ram_addr_3),
    .ram_rdata_3 (ram_rdata_3),
    .ram_wdata_3 (ram_wdata_3)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 256; a++) sbox[a] <= 8'(a);
    end else if (ram_wen) begin
      sbox[ram_waddr_2] <= ram_wdata_2;
      sbox[ram_addr_3]  <= ram_wdata_3;
    end
  end
  assign ram_rdata_1 = sbox[ram_raddr_1];
  assign ram_rdata_3 = sbox[ram_addr_3];

  task automatic do_start(input logic [127:0] k, input logic [4:0] len);
    ks_ready = 1'b0;
    @(negedge clk);
    key     = k;
    key_len = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Gathers n bytes; lat counts clocks from the start edge to the first ks_valid.
  task automatic collect(input int n, input bit bp, output int lat, output int got, output int stable_bad);
    int         cyc = 0;
    int         hold_cnt = 0;
    bit         holding = 0;
    bit         rdy;
    logic [7:0] held = '0;
    lat = -1;
    got = 0;
    stable_bad = 0;
    while (got < n && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (ks_valid) begin
        if (lat < 0) lat = cyc;
        if (holding && ks_data !== held) stable_bad++;
        rdy = !bp || hold_cnt >= 20 || ($urandom_range(0, 2) == 0);
        if (rdy) begin
          if (got < 16) got_bytes[got] = ks_data;
          got++;
          holding  = 0;
          hold_cnt = 0;
        end else begin
          holding = 1;
          held    = ks_data;
          hold_cnt++;
        end
        ks_ready = rdy;
      end else begin
        holding  = 0;
        ks_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; key = '0; key_len = '0; ks_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (ks_valid !== 1'b0) begin bad++; $display("FAIL reset_ks_valid got=%b want=0", ks_valid); end
    total++; if (ks_data !== 8'h00) begin bad++; $display("FAIL reset_ks_data got=%h want=00", ks_data); end
    total++; if (ram_wen !== 1'b0)  begin bad++; $display("FAIL reset_ram_wen got=%b want=0", ram_wen); end
    total++; if ({ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3} !== 40'h0)
      begin bad++; $display("FAIL reset_ram_bus got=%h want=0", {ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || ram_wen !== 1'b0)
      begin bad++; $display("FAIL idle_after_reset busy=%b wen=%b want=0/0", busy, ram_wen); end
  endtask

  task automatic test_key;
    int lat, got, sb;
    do_start(KEY_KEY, 5'd3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL key_busy got=%b want=1", busy); end
    collect(10, 0, lat, got, sb);
    total++; if (lat !== 643) begin bad++; $display("FAIL key_latency got=%0d want=643", lat); end
    total++; if (got !== 10)  begin bad++; $display("FAIL key_count got=%0d want=10", got); end
    for (int b = 0; b < 10; b++) begin
      total++;
      if (got_bytes[b] !== exp_key[b]) begin bad++; $display("FAIL key_byte%0d got=%h want=%h", b, got_bytes[b], exp_key[b]); end
    end
  endtask

  task automatic test_wiki;
    int lat, got, sb;
    do_start(KEY_WIKI, 5'd4);
    collect(6, 0, lat, got, sb);
    total++; if (got !== 6) begin bad++; $display("FAIL wiki_count got=%0d want=6", got); end
    for (int b = 0; b < 6; b++) begin
      total++;
      if (got_bytes[b] !== exp_wiki[b]) begin bad++; $display("FAIL wiki_byte%0d got=%h want=%h", b, got_bytes[b], exp_wiki[b]); end
    end
  endtask

  task automatic test_secret;
    int lat, got, sb;
    do_start(KEY_SECRET, 5'd6);
    collect(8, 0, lat, got, sb);
    total++; if (got !== 8) begin bad++; $display("FAIL secret_count got=%0d want=8", got); end
    for (int b = 0; b < 8; b++) begin
      total++;
      if (got_bytes[b] !== exp_secret[b]) begin bad++; $display("FAIL secret_byte%0d got=%h want=%h", b, got_bytes[b], exp_secret[b]); end
    end
  endtask

  task automatic test_backpressure;
    int lat, got, sb;
    do_start(KEY_KEY, 5'd3);
    collect(10, 1, lat, got, sb);
    total++; if (lat !== 643) begin bad++; $display("FAIL bp_latency got=%0d want=643", lat); end
    total++; if (sb !== 0)    begin bad++; $display("FAIL bp_data_stable changes=%0d want=0", sb); end
    total++; if (got !== 10)  begin bad++; $display("FAIL bp_count got=%0d want=10", got); end
    for (int b = 0; b < 10; b++) begin
      total++;
      if (got_bytes[b] !== exp_key[b]) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", b, got_bytes[b], exp_key[b]); end
    end
  endtask

  task automatic test_bad_len;
    logic [4:0] lens [0:1] = '{5'd0, 5'd17};
    int wen_cnt;
    for (int n = 0; n < 2; n++) begin
      do_start(KEY_WIKI, lens[n]);
      total++; if (err !== 1'b1)     begin bad++; $display("FAIL badlen%0d_err got=%b want=1", lens[n], err); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL badlen%0d_busy got=%b want=0", lens[n], busy); end
      wen_cnt = 0;
      @(negedge clk);
      total++; if (err !== 1'b0)     begin bad++; $display("FAIL badlen%0d_err_pulse got=%b want=0", lens[n], err); end
      for (int c = 0; c < 10; c++) begin
        if (ram_wen !== 1'b0 || busy !== 1'b0) wen_cnt++;
        @(negedge clk);
      end
      total++; if (wen_cnt !== 0)    begin bad++; $display("FAIL badlen%0d_activity got=%0d want=0", lens[n], wen_cnt); end
    end
  endtask

  task automatic test_abort;
    int lat, got, sb;
    do_start(KEY_WIKI, 5'd4);
    repeat (300) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_mid_ksa_busy got=%b want=1", busy); end
    do_start(KEY_WIKI, 5'd4);
    collect(3, 0, lat, got, sb);
    total++; if (lat !== 643) begin bad++; $display("FAIL abort_wiki_latency got=%0d want=643", lat); end
    for (int b = 0; b < 3; b++) begin
      total++;
      if (got_bytes[b] !== exp_wiki[b]) begin bad++; $display("FAIL abort_wiki_byte%0d got=%h want=%h", b, got_bytes[b], exp_wiki[b]); end
    end
    do_start(KEY_KEY, 5'd3);
    total++; if (ks_valid !== 1'b0) begin bad++; $display("FAIL abort_discard got=%b want=0", ks_valid); end
    collect(10, 0, lat, got, sb);
    total++; if (lat !== 643) begin bad++; $display("FAIL abort_key_latency got=%0d want=643", lat); end
    for (int b = 0; b < 10; b++) begin
      total++;
      if (got_bytes[b] !== exp_key[b]) begin bad++; $display("FAIL abort_key_byte%0d got=%h want=%h", b, got_bytes[b], exp_key[b]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, got, sb;
    int waited = 0;
    do_start(KEY_KEY, 5'd3);
    collect(2, 0, lat, got, sb);
    @(negedge clk);
    ks_ready = 1'b0;
    while (!ks_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++; if (ks_valid !== 1'b1 || ks_data !== 8'h77)
      begin bad++; $display("FAIL rstmid_pre got=%b/%h want=1/77", ks_valid, ks_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ks_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ks_valid got=%b want=0", ks_valid); end
    total++; if (ks_data !== 8'h00) begin bad++; $display("FAIL rstmid_ks_data got=%h want=00", ks_data); end
    total++; if (busy !== 1'b0 || err !== 1'b0 || ram_wen !== 1'b0)
      begin bad++; $display("FAIL rstmid_ctrl busy=%b err=%b wen=%b want=0/0/0", busy, err, ram_wen); end
    total++; if ({ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3} !== 40'h0)
      begin bad++; $display("FAIL rstmid_ram_bus got=%h want=0", {ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3}); end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(KEY_KEY, 5'd3);
    collect(10, 0, lat, got, sb);
    total++; if (lat !== 643) begin bad++; $display("FAIL rstmid_latency got=%0d want=643", lat); end
    for (int b = 0; b < 10; b++) begin
      total++;
      if (got_bytes[b] !== exp_key[b]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", b, got_bytes[b], exp_key[b]); end
    end
  endtask

  initial begin
    test_reset;
    test_key;
    test_wiki;
    test_secret;
    test_backpressure;
    test_bad_len;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
